// File: rtl/array_responder_pkg.sv
// Shared types and constants for the array responder: FSM state encoding
// and the width of the kernel run-length counter.
package array_responder_pkg;

  localparam int CYCLES_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_KICK = 3'd2,
    S_RUN  = 3'd3,
    S_DUMP = 3'd4,
    S_DONE = 3'd5
  } resp_state_t;

endpackage

// File: rtl/array_responder_mem.sv
// Array storage: one synchronous write port shared by host load and kernel,
// plus combinational read taps that the top level registers.
module array_responder_mem
  import array_responder_pkg::*;
#(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] kaddr,
  output logic [DATA_W-1:0] kdata,
  input  logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] ddata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage update; the whole array clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign kdata = mem_r[kaddr];
  assign ddata = mem_r[daddr];

endmodule

// File: rtl/array_responder.sv
// Memory-side responder for a kernel array port: preloads the array from
// the host, kicks the kernel, serves its accesses, then dumps the array.
module array_responder
  import array_responder_pkg::*;
#(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   arr_addr,
  input  logic                arr_wenable,
  input  logic [DATA_W-1:0]   arr_wdata,
  output logic [DATA_W-1:0]   arr_rdata,
  output logic                r_enable,
  input  logic                w_enable,
  input  logic                host_start,
  input  logic                load_valid,
  input  logic [DATA_W-1:0]   load_data,
  output logic                load_ready,
  output logic                dump_valid,
  output logic [DATA_W-1:0]   dump_data,
  output logic                dump_last,
  output logic                done,
  output logic [CYCLES_W-1:0] cycles
);

  localparam logic [ADDR_W-1:0]   LAST_IDX   = ADDR_W'(DEPTH - 1);
  localparam logic [CYCLES_W-1:0] CYCLES_MAX = {CYCLES_W{1'b1}};

  resp_state_t         state_r;
  resp_state_t         state_s;
  logic [ADDR_W-1:0]   idx_r;
  logic                w_prev_r;

  logic                idx_last_s;
  logic                load_fire_s;
  logic                w_rise_s;
  logic                kern_we_s;
  logic                dump_emit_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   kern_q_s;
  logic [DATA_W-1:0]   dump_q_s;
  logic [DATA_W-1:0]   dump_word_s;

  logic                load_ready_s;
  logic                r_enable_s;
  logic                dump_valid_s;
  logic                dump_last_s;
  logic                done_s;
  logic [DATA_W-1:0]   dump_data_s;
  logic [DATA_W-1:0]   arr_rdata_s;
  logic [CYCLES_W-1:0] cycles_s;

  assign idx_last_s  = (idx_r == LAST_IDX);
  assign load_fire_s = (state_r == S_LOAD) && load_valid && load_ready;
  assign w_rise_s    = w_enable && !w_prev_r;
  assign kern_we_s   = (state_r == S_RUN) && arr_wenable;
  assign dump_emit_s = (state_s == S_DUMP);

  // Write-port arbitration between host load and kernel.
  always_comb begin
    mem_we_s = load_fire_s || kern_we_s;
    if (load_fire_s) begin
      mem_waddr_s = idx_r;
      mem_wdata_s = load_data;
    end else begin
      mem_waddr_s = arr_addr;
      mem_wdata_s = arr_wdata;
    end
  end

  // The first dump word is captured on the completion edge, whose kernel
  // write has not landed yet, so forward it when it hits the same word.
  assign dump_word_s = (kern_we_s && (arr_addr == idx_r)) ? arr_wdata : dump_q_s;

  array_responder_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .kaddr (arr_addr),
    .kdata (kern_q_s),
    .daddr (idx_r),
    .ddata (dump_q_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (host_start) state_s = S_LOAD;
        else            state_s = S_IDLE;
      end
      S_LOAD: begin
        if (load_fire_s && idx_last_s) state_s = S_KICK;
        else                           state_s = S_LOAD;
      end
      S_KICK: state_s = S_RUN;
      S_RUN: begin
        if (w_rise_s) state_s = S_DUMP;
        else          state_s = S_RUN;
      end
      S_DUMP: begin
        if (dump_last) state_s = S_DONE;
        else           state_s = S_DUMP;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode: next values of every registered output.
  always_comb begin
    load_ready_s = (state_s == S_LOAD);
    r_enable_s   = (state_s == S_KICK);
    dump_valid_s = dump_emit_s;
    dump_last_s  = dump_emit_s && idx_last_s;
    done_s       = (state_s == S_DONE);
    if (dump_emit_s) dump_data_s = dump_word_s;
    else             dump_data_s = {DATA_W{1'b0}};
    if (state_r == S_RUN) arr_rdata_s = kern_q_s;
    else                  arr_rdata_s = arr_rdata;
    if ((state_r == S_IDLE) && host_start) begin
      cycles_s = {CYCLES_W{1'b0}};
    end else if ((state_r == S_RUN) && (cycles != CYCLES_MAX)) begin
      cycles_s = cycles + {{(CYCLES_W-1){1'b0}}, 1'b1};
    end else begin
      cycles_s = cycles;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ready <= 1'b0;
      r_enable   <= 1'b0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
      dump_data  <= {DATA_W{1'b0}};
      arr_rdata  <= {DATA_W{1'b0}};
      cycles     <= {CYCLES_W{1'b0}};
    end else begin
      load_ready <= load_ready_s;
      r_enable   <= r_enable_s;
      dump_valid <= dump_valid_s;
      dump_last  <= dump_last_s;
      done       <= done_s;
      dump_data  <= dump_data_s;
      arr_rdata  <= arr_rdata_s;
      cycles     <= cycles_s;
    end
  end

  // Shared load/dump index and the completion edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= {ADDR_W{1'b0}};
      w_prev_r <= 1'b0;
    end else begin
      w_prev_r <= w_enable;
      if ((state_r == S_IDLE) && host_start) begin
        idx_r <= {ADDR_W{1'b0}};
      end else if (load_fire_s || dump_emit_s) begin
        idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
